// File: rtl/silly_pkg.sv
// Shared types and sizes for the silly gate truth-table sweep controller.
package silly_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int ERR_W       = 4;
    localparam int SETTLE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/silly_sweep_ctrl.sv
// Sweeps {a,b,c} through all eight vectors, checks y/z against expected
// tables and reports error count, first failing index and pass.
module silly_sweep_ctrl
    import silly_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       exp_y,
    input  logic [7:0]       exp_z,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             fail_valid
);

    // state     | meaning
    // ST_IDLE   | waiting for start, results held
    // ST_DRIVE  | vector idx applied, settle counter running down
    // ST_SAMPLE | compare y/z against expected bits for idx
    // ST_DONE   | one-cycle done pulse, then back to idle

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]    ERR_MAX     = ERR_W'(NUM_VECTORS);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_VECTORS - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [IDX_W-1:0]    ffi_q, ffi_d;
    logic                fv_q, fv_d;
    logic                pass_q, pass_d;
    logic                mismatch;

    assign mismatch = (y != exp_y[idx_q]) || (z != exp_z[idx_q]);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        ffi_d    = ffi_q;
        fv_d     = fv_q;
        pass_d   = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    settle_d = SETTLE_LOAD;
                    err_d    = '0;
                    ffi_d    = '0;
                    fv_d     = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (settle_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        ffi_d = idx_q;
                    end
                end
                // pass is resolved here so it is already valid alongside done
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d  = ST_DRIVE;
                    idx_d    = idx_q + 1'b1;
                    settle_d = SETTLE_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ffi_q    <= '0;
            fv_q     <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffi_q    <= ffi_d;
            fv_q     <= fv_d;
            pass_q   <= pass_d;
        end
    end

    assign {a, b, c}      = ((state_q == ST_DRIVE) || (state_q == ST_SAMPLE)) ? idx_q : '0;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;
    assign fail_valid     = fv_q;

endmodule

// File: tb/tb_silly_sweep_ctrl.sv
// Bench for silly_sweep_ctrl: two instances (settle 1 and 3) checked every
// cycle against a position-in-sweep model, plus directed literal checks.
module tb_silly_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start [2];
    logic [7:0] exp_y [2];
    logic [7:0] exp_z [2];
    logic [7:0] inj_y [2];
    logic [7:0] inj_z [2];
    logic       a [2], b [2], c [2];
    logic       y [2], z [2];
    logic       busy [2], done [2], pass [2], fail_valid [2];
    logic [3:0] err_count [2];
    logic [2:0] first_fail_idx [2];
    logic [2:0] abc [2];

    int  total = 0;
    int  bad = 0;
    bit  chk_en = 1'b0;

    // model state: position n within a sweep (1 = first cycle after acceptance)
    bit  m_act [2];
    int  m_n [2];
    int  m_err [2];
    int  m_ffi [2];
    bit  m_fv [2];
    bit  m_ps [2];

    always #5 clk = ~clk;

    assign abc[0] = {a[0], b[0], c[0]};
    assign abc[1] = {a[1], b[1], c[1]};
    assign y[0] = exp_y[0][abc[0]] ^ inj_y[0][abc[0]];
    assign z[0] = exp_z[0][abc[0]] ^ inj_z[0][abc[0]];
    assign y[1] = exp_y[1][abc[1]] ^ inj_y[1][abc[1]];
    assign z[1] = exp_z[1][abc[1]] ^ inj_z[1][abc[1]];

    silly_sweep_ctrl #(.SETTLE_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .exp_y(exp_y[0]), .exp_z(exp_z[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .y(y[0]), .z(z[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err_count[0]), .first_fail_idx(first_fail_idx[0]),
        .fail_valid(fail_valid[0])
    );

    silly_sweep_ctrl #(.SETTLE_CYCLES(3)) u1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .exp_y(exp_y[1]), .exp_z(exp_z[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .y(y[1]), .z(z[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err_count[1]), .first_fail_idx(first_fail_idx[1]),
        .fail_valid(fail_valid[1])
    );

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", name, i, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int len;
            int k;
            int ix;
            len = settle_of(i) + 1;
            if (reset) begin
                m_act[i] = 1'b0; m_n[i] = 0; m_err[i] = 0;
                m_ffi[i] = 0; m_fv[i] = 1'b0; m_ps[i] = 1'b0;
            end else if (m_act[i]) begin
                if (m_n[i] <= 8 * len) begin
                    k  = m_n[i] - 1;
                    ix = k / len;
                    if (k % len == len - 1) begin
                        if (inj_y[i][ix] || inj_z[i][ix]) begin
                            if (!m_fv[i]) begin
                                m_fv[i] = 1'b1;
                                m_ffi[i] = ix;
                            end
                            if (m_err[i] < 8) m_err[i]++;
                        end
                        if (ix == 7) m_ps[i] = (m_err[i] == 0);
                    end
                    m_n[i]++;
                end else begin
                    m_act[i] = 1'b0;
                    m_n[i] = 0;
                end
            end else if (start[i]) begin
                m_act[i] = 1'b1; m_n[i] = 1; m_err[i] = 0;
                m_ffi[i] = 0; m_fv[i] = 1'b0; m_ps[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int len;
                int e_abc;
                int e_busy;
                int e_done;
                len = settle_of(i) + 1;
                e_abc = 0; e_busy = 0; e_done = 0;
                if (m_act[i] && m_n[i] <= 8 * len) begin
                    e_abc = (m_n[i] - 1) / len;
                    e_busy = 1;
                end else if (m_act[i]) begin
                    e_busy = 1;
                    e_done = 1;
                end
                check("abc", i, int'(abc[i]), e_abc);
                check("busy", i, int'(busy[i]), e_busy);
                check("done", i, int'(done[i]), e_done);
                check("pass", i, int'(pass[i]), int'(m_ps[i]));
                check("err_count", i, int'(err_count[i]), m_err[i]);
                check("fail_valid", i, int'(fail_valid[i]), int'(m_fv[i]));
                check("first_fail_idx", i, int'(first_fail_idx[i]), m_ffi[i]);
            end
        end
    end

    task automatic sweep(input int i, input logic [7:0] iy, input logic [7:0] iz, output int lat);
        exp_y[i] = 8'hA5; exp_z[i] = 8'h3C;
        inj_y[i] = iy; inj_z[i] = iz;
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        lat = 1;
        while (done[i] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("done_timeout", i, lat, 0);
    endtask

    initial begin
        int lat;
        int gap;
        int n_done;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; exp_y[i] = 8'hA5; exp_z[i] = 8'h3C;
            inj_y[i] = 8'h00; inj_z[i] = 8'h00;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst_abc", i, int'(abc[i]), 0);
            check("rst_busy", i, int'(busy[i]), 0);
            check("rst_done", i, int'(done[i]), 0);
            check("rst_pass", i, int'(pass[i]), 0);
            check("rst_err", i, int'(err_count[i]), 0);
            check("rst_fv", i, int'(fail_valid[i]), 0);
        end

        // clean sweep, settle 1
        sweep(0, 8'h00, 8'h00, lat);
        check("lat_s1", 0, lat, 17);
        check("clean_pass", 0, int'(pass[0]), 1);
        check("clean_err", 0, int'(err_count[0]), 0);
        check("clean_fv", 0, int'(fail_valid[0]), 0);
        @(negedge clk);
        check("hold_pass", 0, int'(pass[0]), 1);
        check("idle_busy", 0, int'(busy[0]), 0);

        // y inverted at index 5
        sweep(0, 8'h20, 8'h00, lat);
        check("one_err", 0, int'(err_count[0]), 1);
        check("one_ffi", 0, int'(first_fail_idx[0]), 5);
        check("one_fv", 0, int'(fail_valid[0]), 1);
        check("one_pass", 0, int'(pass[0]), 0);

        // everything inverted
        sweep(0, 8'hFF, 8'hFF, lat);
        check("all_err", 0, int'(err_count[0]), 8);
        check("all_ffi", 0, int'(first_fail_idx[0]), 0);
        check("all_pass", 0, int'(pass[0]), 0);

        // settle 3
        sweep(1, 8'h00, 8'h00, lat);
        check("lat_s3", 1, lat, 33);
        check("s3_pass", 1, int'(pass[1]), 1);
        check("s3_err", 1, int'(err_count[1]), 0);
        check("s3_fv", 1, int'(fail_valid[1]), 0);

        // start held high: back-to-back sweeps with one idle cycle between
        inj_y[0] = 8'h20; inj_z[0] = 8'h00;
        @(negedge clk);
        start[0] = 1'b1;
        lat = 0;
        while (done[0] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("held_timeout1", 0, lat, 0);
        check("held_err_done", 0, int'(err_count[0]), 1);
        @(negedge clk);
        check("held_idle_busy", 0, int'(busy[0]), 0);
        check("held_idle_err", 0, int'(err_count[0]), 1);
        @(negedge clk);
        check("held_restart_busy", 0, int'(busy[0]), 1);
        check("held_clear_err", 0, int'(err_count[0]), 0);
        check("held_clear_fv", 0, int'(fail_valid[0]), 0);
        gap = 2;
        while (done[0] !== 1'b1 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        check("held_gap", 0, gap, 18);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-sweep while idx == 3
        inj_y[0] = 8'h00;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        lat = 0;
        while (abc[0] != 3'd3 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) check("idx3_timeout", 0, lat, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_abc", 0, int'(abc[0]), 0);
        check("mrst_busy", 0, int'(busy[0]), 0);
        check("mrst_done", 0, int'(done[0]), 0);
        check("mrst_err", 0, int'(err_count[0]), 0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[0] === 1'b1) n_done++;
        end
        check("mrst_no_done", 0, n_done, 0);

        // randomized traffic on both instances
        repeat (3000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                if (!m_act[i] && $urandom_range(0, 5) == 0) begin
                    exp_y[i] = 8'($urandom);
                    exp_z[i] = 8'($urandom);
                    case ($urandom_range(0, 3))
                        0: begin inj_y[i] = 8'h00; inj_z[i] = 8'h00; end
                        1: begin inj_y[i] = 8'($urandom); inj_z[i] = 8'($urandom); end
                        default: begin
                            inj_y[i] = 8'($urandom & $urandom & $urandom);
                            inj_z[i] = 8'($urandom & $urandom & $urandom);
                        end
                    endcase
                end
            end
        end
        reset = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
